// File: rtl/mix_bus_accumulator.sv
// Mix bus multiply-accumulate engine.
// Sums sample*gain over a frame and emits one saturated Q6.30 word per frame.
module mix_bus_accumulator #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SAMPLE_FRAC  = 20,
    parameter int COEF_WIDTH   = 18,
    parameter int COEF_FRAC    = 16,
    parameter int ACC_WIDTH    = 36,
    parameter int ACC_FRAC     = 30
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
    input  logic signed [COEF_WIDTH-1:0]   in_coef,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_WIDTH-1:0]    out_data,
    output logic                           out_overflow
);

    localparam int SHIFT = SAMPLE_FRAC + COEF_FRAC - ACC_FRAC;
    localparam int PW    = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int AW1   = ACC_WIDTH + 1;
    localparam int MW    = (PW > AW1) ? PW : AW1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    state_t state_q, state_d;

    logic                        accept;
    logic signed [PW-1:0]        prod;
    logic signed [MW-1:0]        prod_wide;
    logic signed [AW1-1:0]       p_d, p_q;
    logic                        pv_q;
    logic                        plast_q;

    logic signed [AW1-1:0]       sum;
    logic                        sum_ovf;
    logic signed [ACC_WIDTH-1:0] sum_sat;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        sticky_q, sticky_d;
    logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_ovf_q, out_ovf_d;

    assign accept = in_valid && in_ready;

    // Stage 1: full-width product, rescaled to accumulator format (floor).
    always_comb begin
        prod      = PW'(in_sample) * PW'(in_coef);
        prod_wide = MW'(prod);
        p_d       = AW1'(prod_wide >>> SHIFT);
    end

    // Stage 2: one guard bit detects leaving the accumulator range.
    always_comb begin
        sum     = AW1'(acc_q) + p_q;
        sum_ovf = sum[AW1-1] ^ sum[AW1-2];
        if (sum_ovf) begin
            sum_sat = sum[AW1-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum[ACC_WIDTH-1:0];
        end
    end

    // Accumulate or close the frame when a product is pending.
    always_comb begin
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (pv_q) begin
            if (plast_q) begin
                out_data_d = sum_sat;
                out_ovf_d  = sticky_q | sum_ovf;
                acc_d      = '0;
                sticky_d   = 1'b0;
            end else begin
                acc_d      = sum_sat;
                sticky_d   = sticky_q | sum_ovf;
            end
        end
    end

    // Frame sequencing and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q        <= '0;
            pv_q       <= 1'b0;
            plast_q    <= 1'b0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            pv_q       <= accept;
            if (accept) begin
                p_q     <= p_d;
                plast_q <= in_last;
            end
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mix_bus_accumulator.sv
// Directed bench for mix_bus_accumulator.
// An integer model pushes expected frame sums; outputs are popped and compared.
module tb_mix_bus_accumulator;

    localparam longint MAXV = 64'sd34359738367;
    localparam longint MINV = -64'sd34359738368;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_sample;
    logic [17:0] in_coef;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_data;
    logic        out_overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [35:0] d;
        logic        o;
    } exp_t;

    exp_t   sb[$];
    longint m_acc    = 0;
    bit     m_sticky = 1'b0;

    mix_bus_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sample    (in_sample),
        .in_coef      (in_coef),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic void model(input logic signed [23:0] s,
                                  input logic signed [17:0] c,
                                  input logic last);
        longint p;
        longint sum;
        bit     ov;
        exp_t   e;
        p   = (longint'(s) * longint'(c)) >>> 6;
        sum = m_acc + p;
        ov  = 1'b0;
        if (sum > MAXV) begin
            sum = MAXV;
            ov  = 1'b1;
        end else if (sum < MINV) begin
            sum = MINV;
            ov  = 1'b1;
        end
        if (last) begin
            e.d = sum[35:0];
            e.o = m_sticky | ov;
            sb.push_back(e);
            m_acc    = 0;
            m_sticky = 1'b0;
        end else begin
            m_acc    = sum;
            m_sticky = m_sticky | ov;
        end
    endfunction

    task automatic send(input logic [23:0] s, input logic [17:0] c,
                        input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = s;
        in_coef   = c;
        in_last   = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("in_ready_wait");
        end else begin
            @(posedge clk);
            model(s, c, last);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            fail_now({tag, "_valid_wait"});
            return;
        end
        if (sb.size() == 0) begin
            fail_now({tag, "_sb_empty"});
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data"}, 64'(out_data), 64'(e.d));
        chk({tag, "_ovf"}, 64'(out_overflow), 64'(e.o));
        chk({tag, "_inrdy_busy"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_inrdy_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        exp_t e;
        int   n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        in_coef   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ovf", 64'(out_overflow), 64'd0);
        reset = 1'b0;

        // Unit term with latency check
        send(24'h100000, 18'h10000, 1'b1);
        @(negedge clk);
        chk("lat_t1_valid", 64'(out_valid), 64'd0);
        chk("lat_t1_inrdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("lat_t2_valid", 64'(out_valid), 64'd1);
        chk("unit_const", 64'(out_data), 64'h0_4000_0000);
        get_result("unit");

        // Three terms back to back
        send(24'h100000, 18'h10000, 1'b0);
        send(24'h080000, 18'h10000, 1'b0);
        send(24'h100000, 18'h30000, 1'b1);
        get_result("sum3");

        // Saturation, then sticky cleared
        send(24'h800000, 18'h20000, 1'b0);
        send(24'h800000, 18'h20000, 1'b0);
        send(24'h800000, 18'h20000, 1'b1);
        get_result("sat");
        send(24'h100000, 18'h10000, 1'b1);
        get_result("after_sat");

        // Truncation toward -inf
        send(24'h000001, 18'h00001, 1'b1);
        get_result("trunc_pos");
        send(24'hFFFFFF, 18'h00001, 1'b1);
        get_result("trunc_neg");

        // Input gap mid-frame
        send(24'h100000, 18'h10000, 1'b0);
        repeat (3) @(negedge clk);
        send(24'h080000, 18'h10000, 1'b1);
        get_result("gap");

        // Backpressure
        out_ready = 1'b0;
        send(24'h080000, 18'h30000, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid || sb.size() == 0) begin
            fail_now("bp_valid_wait");
        end else begin
            e = sb[0];
            for (int i = 0; i < 5; i++) begin
                chk("bp_data", 64'(out_data), 64'(e.d));
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_inrdy", 64'(in_ready), 64'd0);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        get_result("bp");
        send(24'h100000, 18'h10000, 1'b1);
        get_result("after_bp");

        // Reset mid-frame
        send(24'h100000, 18'h10000, 1'b0);
        send(24'h100000, 18'h10000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        m_acc    = 0;
        m_sticky = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_data", 64'(out_data), 64'd0);
        chk("mrst_out_ovf", 64'(out_overflow), 64'd0);
        reset = 1'b0;
        send(24'h100000, 18'h10000, 1'b1);
        get_result("after_rst");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
